// File: rtl/qpp_address_gen_if.sv
// Handshake bundle between the QPP address generator and its block controller / read port.
// The master drives start/block_size/addr_ready; the slave (generator) returns the address stream.
interface qpp_address_gen_if #(
   parameter int AW = 13
);
   logic          start;
   logic          block_size;
   logic          addr_ready;
   logic          addr_valid;
   logic [AW-1:0] addr;
   logic [AW-1:0] index;
   logic          last;
   logic          busy;
   logic          done;

   modport master (
      output start, block_size, addr_ready,
      input  addr_valid, addr, index, last, busy, done
   );

   modport slave (
      input  start, block_size, addr_ready,
      output addr_valid, addr, index, last, busy, done
   );
endinterface

// File: rtl/qpp_address_gen.sv
// LTE turbo QPP interleaver address generator: pi(i) = (F1*i + F2*i^2) mod K,
// produced by second-order recursion using only add and conditional subtract.
module qpp_address_gen #(
   parameter int AW       = 13,
   parameter int K_SMALL  = 1056,
   parameter int F1_SMALL = 17,
   parameter int F2_SMALL = 66,
   parameter int K_LARGE  = 6144,
   parameter int F1_LARGE = 263,
   parameter int F2_LARGE = 480
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   qpp_address_gen_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   localparam logic [AW-1:0] KS  = AW'(K_SMALL);
   localparam logic [AW-1:0] F1S = AW'(F1_SMALL);
   localparam logic [AW-1:0] F2S = AW'(F2_SMALL);
   localparam logic [AW-1:0] KL  = AW'(K_LARGE);
   localparam logic [AW-1:0] F1L = AW'(F1_LARGE);
   localparam logic [AW-1:0] F2L = AW'(F2_LARGE);

   state_e        state_q, state_d;
   logic [AW-1:0] k_q, k_d;
   logic [AW-1:0] pi_q, pi_d;
   logic [AW-1:0] g_q, g_d;
   logic [AW-1:0] dg_q, dg_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          vld_q, vld_d;
   logic          xfer;
   logic          at_last;

   // Both operands must already lie in [0,K-1], so one subtraction always suffices.
   function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                             input logic [AW-1:0] b,
                                             input logic [AW-1:0] k);
      logic [AW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, k}) s = s - {1'b0, k};
      return s[AW-1:0];
   endfunction

   assign xfer    = vld_q & bus.addr_ready;
   assign at_last = (idx_q == (k_q - AW'(1)));

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      pi_d    = pi_q;
      g_d     = g_q;
      dg_d    = dg_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               vld_d   = 1'b1;
               pi_d    = '0;
               idx_d   = '0;
               if (bus.block_size) begin
                  k_d  = KL;
                  g_d  = mod_add(F1L, F2L, KL);
                  dg_d = mod_add(F2L, F2L, KL);
               end else begin
                  k_d  = KS;
                  g_d  = mod_add(F1S, F2S, KS);
                  dg_d = mod_add(F2S, F2S, KS);
               end
            end
         end
         RUN: begin
            if (xfer) begin
               if (at_last) begin
                  // Final address and index stay visible through DONE and IDLE.
                  vld_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  pi_d  = mod_add(pi_q, g_q, k_q);
                  g_d   = mod_add(g_q, dg_q, k_q);
                  idx_d = idx_q + AW'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         k_q     <= '0;
         pi_q    <= '0;
         g_q     <= '0;
         dg_q    <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         pi_q    <= pi_d;
         g_q     <= g_d;
         dg_q    <= dg_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
      end
   end

   assign bus.addr_valid = vld_q;
   assign bus.addr       = pi_q;
   assign bus.index      = idx_q;
   assign bus.last       = vld_q & at_last;
   assign bus.busy       = (state_q == RUN);
   assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_qpp_address_gen.sv
// Directed bench for qpp_address_gen: hand-computed address table plus closed-form
// per-transfer reference, stall, ignored-start, block_size flip and mid-block reset cases.
module tb_qpp_address_gen;

   localparam int AW = 13;

   logic clk;
   logic rst_n;

   qpp_address_gen_if #(.AW(AW)) bus ();

   qpp_address_gen #(.AW(AW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic bs;
      int   idx;
      int   addr;
   } vec_t;

   vec_t vecs[10];
   int   cap[6144];
   bit   seen[6144];
   int   checks;
   int   failures;

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic longint ref_addr(input logic bs, input longint i);
      longint k, f1, f2;
      k  = bs ? 6144 : 1056;
      f1 = bs ? 263 : 17;
      f2 = bs ? 480 : 66;
      return (f1 * i + f2 * i * i) % k;
   endfunction

   task automatic apply_table(input logic bs, input int upto);
      for (int v = 0; v < 10; v++) begin
         if (vecs[v].bs == bs && vecs[v].idx < upto)
            check($sformatf("table_bs%0d_idx%0d", bs, vecs[v].idx), cap[vecs[v].idx], vecs[v].addr);
      end
   endtask

   task automatic run_block(input logic bs, input bit rnd, input bit poke, input int abort_at);
      int kk, ntx, ndone, dups;
      bit fin, aborted;
      kk = bs ? 6144 : 1056;
      ntx = 0; ndone = 0; fin = 1'b0; aborted = 1'b0; dups = 0;
      for (int j = 0; j < 6144; j++) begin cap[j] = -1; seen[j] = 1'b0; end
      @(posedge clk); #1;
      bus.start = 1'b1; bus.block_size = bs; bus.addr_ready = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_after_start", bus.busy, 1);
      for (int cyc = 0; cyc < 40000 && !fin; cyc++) begin
         bus.addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke) begin
            bus.start      = (ntx == 10);
            bus.block_size = (ntx >= 10) ? ~bs : bs;
         end
         if (abort_at >= 0 && ntx == abort_at) begin
            rst_n = 1'b0;
            #1;
            check("abort_valid", bus.addr_valid, 0);
            check("abort_addr", bus.addr, 0);
            check("abort_index", bus.index, 0);
            check("abort_last", bus.last, 0);
            check("abort_busy", bus.busy, 0);
            bus.start = 1'b0; bus.addr_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               if (bus.done) ndone++;
            end
            rst_n = 1'b1;
            aborted = 1'b1;
            fin = 1'b1;
         end else begin
            @(negedge clk);
            if (bus.addr_valid) begin
               check("index", bus.index, ntx);
               check("addr", bus.addr, ref_addr(bs, ntx));
               check("last", bus.last, (ntx == kk - 1));
               if (bus.addr_ready) begin
                  cap[ntx] = int'(bus.addr);
                  if (bus.addr < kk) begin
                     if (seen[bus.addr]) dups++;
                     seen[bus.addr] = 1'b1;
                  end else dups++;
                  ntx++;
               end
            end
            if (bus.done) begin
               ndone++;
               fin = 1'b1;
               check("done_valid_low", bus.addr_valid, 0);
               check("done_addr_hold", bus.addr, ref_addr(bs, kk - 1));
               check("done_index_hold", bus.index, kk - 1);
            end
            @(posedge clk); #1;
         end
      end
      bus.start = 1'b0;
      check("block_finished", fin, 1);
      if (aborted) begin
         check("abort_transfers", ntx, abort_at);
         check("abort_no_done", ndone, 0);
      end else begin
         check("transfers", ntx, kk);
         check("done_pulses", ndone, 1);
         check("permutation_dups", dups, 0);
         @(negedge clk);
         check("done_one_cycle", bus.done, 0);
         check("idle_busy", bus.busy, 0);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      vecs[0] = '{1'b0, 0, 0};
      vecs[1] = '{1'b0, 1, 83};
      vecs[2] = '{1'b0, 2, 298};
      vecs[3] = '{1'b0, 3, 645};
      vecs[4] = '{1'b0, 1055, 49};
      vecs[5] = '{1'b1, 0, 0};
      vecs[6] = '{1'b1, 1, 743};
      vecs[7] = '{1'b1, 2, 2446};
      vecs[8] = '{1'b1, 3, 5109};
      vecs[9] = '{1'b1, 6143, 217};

      rst_n = 1'b0;
      bus.start = 1'b0; bus.block_size = 1'b0; bus.addr_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         bus.start = c[0]; bus.addr_ready = ~c[0]; bus.block_size = c[1];
         @(negedge clk);
         check("rst_valid", bus.addr_valid, 0);
         check("rst_busy", bus.busy, 0);
         check("rst_done", bus.done, 0);
         check("rst_addr", bus.addr, 0);
      end
      @(posedge clk); #1;
      bus.start = 1'b0; bus.addr_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      run_block(1'b0, 1'b0, 1'b0, -1);
      apply_table(1'b0, 1056);
      run_block(1'b1, 1'b0, 1'b0, -1);
      apply_table(1'b1, 6144);
      run_block(1'b0, 1'b1, 1'b0, -1);
      apply_table(1'b0, 1056);
      run_block(1'b0, 1'b0, 1'b1, -1);
      apply_table(1'b0, 1056);
      run_block(1'b0, 1'b0, 1'b0, 500);
      apply_table(1'b0, 500);
      run_block(1'b0, 1'b0, 1'b0, -1);
      apply_table(1'b0, 1056);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
